// File: rtl/mem_bank_if.sv
// Bus bundle between the MIPS datapath and the mem_bank data memory.
// The misaligned flag exists only when MEM_BANK_ALIGN_CHECK_EN is defined.
interface mem_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [3:0]        byteen;
  logic [DATA_W-1:0] readdata;
`ifdef MEM_BANK_ALIGN_CHECK_EN
  logic              misaligned;

  modport master (
    output memread, memwrite, address, writedata, byteen,
    input  readdata, misaligned
  );
  modport slave (
    input  memread, memwrite, address, writedata, byteen,
    output readdata, misaligned
  );
`else
  modport master (
    output memread, memwrite, address, writedata, byteen,
    input  readdata
  );
  modport slave (
    input  memread, memwrite, address, writedata, byteen,
    output readdata
  );
`endif
endinterface

// File: rtl/mem_bank.sv
// Word-organised data memory: combinational read, byte-enabled synchronous write,
// async active-low clear. Optional alignment check via MEM_BANK_ALIGN_CHECK_EN.
module mem_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_bank_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0]  word;
  logic              wr_en;
  logic              unused_addr;

  // Upper address bits beyond DEPTH wrap; low two bits never select storage.
  assign word        = bus.address[IDX_W+1:2];
  assign unused_addr = ^bus.address;

`ifdef MEM_BANK_ALIGN_CHECK_EN
  assign bus.misaligned = (bus.memread | bus.memwrite) & (bus.address[1:0] != 2'b00);
  assign wr_en          = bus.memwrite & ~bus.misaligned;
`else
  assign wr_en          = bus.memwrite;
`endif

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.byteen[i]) mem_d[word][8*i +: 8] = bus.writedata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // No bypass: a same-word write becomes visible only after the edge.
  assign bus.readdata = bus.memread ? mem_q[word] : '0;
endmodule

// File: tb/tb_mem_bank.sv
// Directed, table-driven bench for mem_bank with hand-computed expectations.
module tb_mem_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mem_bank_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  mem_bank #(.DATA_W(32), .ADDR_W(8), .DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
    bus.byteen    = '0;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b1;
    bus.address   = a;
    bus.writedata = d;
    bus.byteen    = be;
    @(posedge clk);
    #1;
    bus.memwrite  = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    bus.memwrite = 1'b0;
    bus.memread  = 1'b1;
    bus.address  = a;
    #1;
    chk(name, bus.readdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'd8,   32'hDEADBEEF, 4'hF,    8'd8,   32'hDEADBEEF, "wr8_rd8"};
    vecs[1]  = '{1'b0, 8'd0,   32'h0,        4'h0,    8'd9,   32'hDEADBEEF, "rd9"};
    vecs[2]  = '{1'b0, 8'd0,   32'h0,        4'h0,    8'd10,  32'hDEADBEEF, "rd10"};
    vecs[3]  = '{1'b0, 8'd0,   32'h0,        4'h0,    8'd11,  32'hDEADBEEF, "rd11"};
    vecs[4]  = '{1'b1, 8'd0,   32'h11223344, 4'hF,    8'd0,   32'h11223344, "wr0_full"};
    vecs[5]  = '{1'b1, 8'd0,   32'hAABBCCDD, 4'b0101, 8'd0,   32'h11BB33DD, "wr0_lanes0101"};
    vecs[6]  = '{1'b1, 8'd0,   32'hFFFFFFFF, 4'h0,    8'd0,   32'h11BB33DD, "wr0_be0_noop"};
    vecs[7]  = '{1'b1, 8'd252, 32'hCAFEF00D, 4'hF,    8'd252, 32'hCAFEF00D, "wr252_top"};
    vecs[8]  = '{1'b0, 8'd0,   32'h0,        4'h0,    8'd0,   32'h11BB33DD, "word0_after_top"};
    vecs[9]  = '{1'b1, 8'd16,  32'hA5A5A5A5, 4'b1000, 8'd16,  32'hA5000000, "wr16_lane3"};
    vecs[10] = '{1'b1, 8'd4,   32'h12345678, 4'hF,    8'd4,   32'h12345678, "wr4_full"};
    vecs[11] = '{1'b1, 8'd20,  32'h0000BEEF, 4'b0011, 8'd20,  32'h0000BEEF, "wr20_lo_half"};

    idle();
    #12;
    chk("reset_hold_read", bus.readdata, 32'h0);
    rst_n = 1'b1;

    // Populate a word, then clear it with a reset pulse between clock edges.
    write_word(8'd40, 32'h600DF00D, 4'hF);
    read_chk("pre_reset_word10", 8'd40, 32'h600DF00D);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear_no_edge", bus.readdata, 32'h0);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 256; a += 4) begin
      bus.address = 8'(a);
      #1;
      chk($sformatf("sweep_zero_%0d", a), bus.readdata, 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) write_word(vecs[i].waddr, vecs[i].wdata, vecs[i].be);
      else @(negedge clk);
      read_chk(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end

    // Misaligned write to addr 6 (word 1 currently 12345678).
    @(negedge clk);
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b1;
    bus.address   = 8'd6;
    bus.writedata = 32'hBBBBBBBB;
    bus.byteen    = 4'hF;
    #1;
`ifdef MEM_BANK_ALIGN_CHECK_EN
    chk("misaligned_flag", {31'b0, bus.misaligned}, 32'h1);
`endif
    @(posedge clk);
    #1;
`ifdef MEM_BANK_ALIGN_CHECK_EN
    read_chk("misaligned_wr_suppressed", 8'd4, 32'h12345678);
    read_chk("misaligned_rd_returns_word", 8'd6, 32'h12345678);
`else
    read_chk("misaligned_wr_lowbits_ignored", 8'd4, 32'hBBBBBBBB);
`endif

    // Read enable gating, no clock edge between the two checks.
    @(negedge clk);
    bus.memread = 1'b0;
    bus.address = 8'd16;
    #1;
    chk("memread0_zero", bus.readdata, 32'h0);
    bus.memread = 1'b1;
    #1;
    chk("memread1_same_cycle", bus.readdata, 32'hA5000000);

    // Read-during-write on addr 12: old 5, new 9.
    write_word(8'd12, 32'h5, 4'hF);
    @(negedge clk);
    bus.memread   = 1'b1;
    bus.memwrite  = 1'b1;
    bus.address   = 8'd12;
    bus.writedata = 32'h9;
    bus.byteen    = 4'hF;
    #1;
    chk("rdw_before_edge", bus.readdata, 32'h5);
    @(posedge clk);
    #1;
    chk("rdw_after_edge", bus.readdata, 32'h9);
    bus.memwrite = 1'b0;

    // Reset held across an edge with a write pending: write discarded.
    @(negedge clk);
    bus.memwrite  = 1'b1;
    bus.address   = 8'd12;
    bus.writedata = 32'h77;
    bus.byteen    = 4'hF;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.memwrite = 1'b0;
    read_chk("reset_beats_write", 8'd12, 32'h0);
    read_chk("reset_cleared_top", 8'd252, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
